// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I load/store port: one request at a time,
// configurable wait states, sign/zero-extended loads and access-error reporting.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam bit HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [3:0] WS_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic        we_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          exec;
  logic          x_we;
  logic [31:0]   x_addr;
  logic [1:0]    x_size;
  logic          x_uns;
  logic [31:0]   x_wdata;
  logic [AW-1:0] x_idx;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_val;
  logic [31:0]   wr_word_d;
  logic          rsp_err_d;
  logic [31:0]   rsp_rdata_d;
  logic          mem_we;

  assign accept = (state_q == S_IDLE) && req_valid;
  assign exec   = (accept && !HAS_WAIT) || ((state_q == S_WAIT) && (cnt_q == 4'd0));

  // With zero wait states the execute edge is the accept edge, so the live
  // request fields are used; otherwise the captured copies are.
  assign x_we    = (state_q == S_IDLE) ? req_we       : we_q;
  assign x_addr  = (state_q == S_IDLE) ? req_addr     : addr_q;
  assign x_size  = (state_q == S_IDLE) ? req_size     : size_q;
  assign x_uns   = (state_q == S_IDLE) ? req_unsigned : uns_q;
  assign x_wdata = (state_q == S_IDLE) ? req_wdata    : wdata_q;

  assign x_idx   = x_addr[AW+1:2];
  assign rd_word = mem[x_idx];
  assign rd_byte = rd_word[{x_addr[1:0], 3'b000} +: 8];
  assign rd_half = rd_word[{x_addr[1], 4'b0000} +: 16];

  // NOTE: every signal assigned in always_comb gets a default at the top so
  // no path through the case statements can leave it unassigned (no latch).
  always_comb begin
    rsp_err_d = 1'b0;
    load_val  = 32'd0;
    wr_word_d = rd_word;

    unique case (size_e'(x_size))
      SZ_BYTE: begin
        load_val = {{24{rd_byte[7] & ~x_uns}}, rd_byte};
        wr_word_d[{x_addr[1:0], 3'b000} +: 8] = x_wdata[7:0];
      end
      SZ_HALF: begin
        rsp_err_d = x_addr[0];
        load_val  = {{16{rd_half[15] & ~x_uns}}, rd_half};
        wr_word_d[{x_addr[1], 4'b0000} +: 16] = x_wdata[15:0];
      end
      SZ_WORD: begin
        rsp_err_d = (x_addr[1:0] != 2'b00);
        load_val  = rd_word;
        wr_word_d = x_wdata;
      end
      SZ_BAD: rsp_err_d = 1'b1;
      default: rsp_err_d = 1'b1;
    endcase

    if ((x_addr >> (AW + 2)) != 32'd0) begin
      rsp_err_d = 1'b1;
    end

    rsp_rdata_d = (rsp_err_d || x_we) ? 32'd0 : load_val;
  end

  // A reset landing on the execute edge must not let a pending store through.
  assign mem_we = exec && x_we && !rsp_err_d && !rst;

  // NOTE: the array has no reset; clearing thousands of words is neither
  // needed nor synthesizable as block RAM, so only control state is reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[x_idx] <= wr_word_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      wdata_q     <= 32'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            size_q      <= req_size;
            uns_q       <= req_unsigned;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (HAS_WAIT) begin
              state_q <= S_WAIT;
              cnt_q   <= WS_LOAD;
            end else begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rsp_rdata_d;
              rsp_err_q   <= rsp_err_d;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= 32'd0;
          rsp_err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array reference model,
// plus directed reset, error, back-pressure and timing scenarios.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int WS    = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mm [0:DEPTH*4-1];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory, sizes as byte counts, extension by arithmetic.
  function automatic void model_exec(input logic we, input logic [31:0] addr,
                                     input logic [1:0] size, input logic uns,
                                     input logic [31:0] wdata,
                                     output logic [31:0] rd, output logic err);
    int n = 1 << size;
    logic [31:0] val = 32'd0;
    err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
          (size == 2'd2 && addr[1:0] != 2'b00) || (addr >= 32'(DEPTH * 4));
    rd = 32'd0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < n; i++) mm[addr + i] = wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) val = val | (32'(mm[addr + i]) << (8 * i));
      if (n < 4 && !uns && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
      rd = val;
    end
  endfunction

  // Tasks start and end just after a falling edge unless noted.
  task automatic send_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata);
    int i = 0;
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid = 1'b1;
    while (!req_ready && i < 40) begin
      @(negedge clk);
      i++;
    end
    check("accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    check("rsp_latency", lat, WS + 1);
  endtask

  task automatic finish_rsp(input logic [31:0] exp_rd, input logic exp_err, input int hold);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, exp_rd);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_req_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata, input int hold);
    logic [31:0] e_rd;
    logic        e_err;
    model_exec(we, addr, size, uns, wdata, e_rd, e_err);
    send_req(we, addr, size, uns, wdata);
    wait_rsp();
    finish_rsp(e_rd, e_err, hold);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e1, e2, a;
    logic        r1, r2;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);

    for (int w = 0; w < 64; w++)
      do_txn(1'b1, 32'(w * 4), 2'd2, 1'b0, (w == 8) ? 32'h0BAD_F00D : $urandom, 0);

    // Store and extended loads
    do_txn(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF, 0);
    do_txn(1'b0, 32'h13, 2'd0, 1'b0, 32'h0, 0);
    do_txn(1'b0, 32'h13, 2'd0, 1'b1, 32'h0, 0);
    do_txn(1'b0, 32'h10, 2'd1, 1'b0, 32'h0, 0);
    do_txn(1'b1, 32'h11, 2'd0, 1'b0, 32'hFFFF_FF55, 0);
    do_txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0);
    do_txn(1'b1, 32'h12, 2'd1, 1'b0, 32'hABCD_1234, 0);
    do_txn(1'b0, 32'h10, 2'd2, 1'b1, 32'h0, 0);

    // Error cases, then the word must be untouched
    do_txn(1'b0, 32'h12, 2'd2, 1'b0, 32'h0, 0);
    do_txn(1'b0, 32'h11, 2'd1, 1'b0, 32'h0, 0);
    do_txn(1'b0, 32'h10, 2'd3, 1'b0, 32'h0, 0);
    do_txn(1'b0, 32'h1000, 2'd2, 1'b0, 32'h0, 0);
    do_txn(1'b1, 32'h1000, 2'd2, 1'b0, 32'h7777_7777, 0);
    do_txn(1'b1, 32'h13, 2'd1, 1'b0, 32'h6666_6666, 0);
    do_txn(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 0);
    do_txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0);

    // Back-pressure with a competing request waiting
    model_exec(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, e1, r1);
    send_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    wait_rsp();
    req_we = 1'b0; req_addr = 32'h12; req_size = 2'd1; req_unsigned = 1'b1; req_valid = 1'b1;
    finish_rsp(e1, r1, 5);
    model_exec(1'b0, 32'h12, 2'd1, 1'b1, 32'h0, e2, r2);
    send_req(1'b0, 32'h12, 2'd1, 1'b1, 32'h0);
    wait_rsp();
    finish_rsp(e2, r2, 0);

    // rsp_ready asserted early
    rsp_ready = 1'b1;
    do_txn(1'b0, 32'h13, 2'd0, 1'b0, 32'h0, 0);

    // Reset during WAIT drops the pending store
    send_req(1'b1, 32'h20, 2'd2, 1'b0, 32'hAAAA_AAAA);
    #1 rst = 1'b1;
    #1;
    check("rstwait_req_ready", 32'(req_ready), 32'd1);
    check("rstwait_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstwait_rsp_rdata", rsp_rdata, 32'd0);
    check("rstwait_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_txn(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 0);

    // Reset during RESP keeps the committed store
    model_exec(1'b1, 32'h24, 2'd2, 1'b0, 32'h5A5A_5A5A, e1, r1);
    send_req(1'b1, 32'h24, 2'd2, 1'b0, 32'h5A5A_5A5A);
    wait_rsp();
    #1 rst = 1'b1;
    #1;
    check("rstresp_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstresp_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_txn(1'b0, 32'h24, 2'd2, 1'b0, 32'h0, 0);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      int hold;
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 9) == 0) a = a | ($urandom_range(1, 4000) << 12);
      hold = $urandom_range(0, 3);
      if (hold == 0 && $urandom_range(0, 1) == 1) rsp_ready = 1'b1;
      do_txn(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, hold);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the RV32I core's load/store port. It accepts one request at a time from the datapath-side initiator over a valid/ready handshake and services byte, halfword and word loads and stores against an internal word-organised array. It adds a configurable number of wait states and returns sign- or zero-extended load data, or an error for misaligned or out-of-range accesses. It sits between the core's ALUResult/WriteData/ReadData path and on-chip data RAM.

## Interface

- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, at least 4); AW = $clog2(DEPTH_WORDS)
- WAIT_STATES, 1, extra cycles between accept and response (0..15)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  initiator presents a request
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response available
- rsp_ready  in  1  initiator takes the response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  request was rejected (no array update)

## Operation

- FSM states IDLE, WAIT, RESP. Reset state IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready capture we, addr, size, unsigned, wdata; go WAIT if WAIT_STATES>0 (load counter with WAIT_STATES-1), else RESP.
- WAIT: req_ready=0; decrement counter; at counter 0 go RESP.
- Transition into RESP is the execute edge: error check, store commit, load sample all happen on that edge from captured fields.
- RESP: rsp_valid=1, rsp_rdata/rsp_err held stable until rsp_ready=1; on rsp_valid&&rsp_ready go IDLE. req_ready=0 in RESP.
- Error when any of: size=11; size=01 and addr[0]=1; size=10 and addr[1:0]!=0; addr[31:AW+2]!=0. Error: rsp_err=1, rsp_rdata=0, array untouched.
- Word index = addr[AW+1:2]; lane = addr[1:0].
- Store byte: write wdata[7:0] into byte lane only. Store half: wdata[15:0] into lanes {addr[1],0}+1:{addr[1],0}. Store word: all four lanes. Other lanes unchanged.
- Load byte: selected lane, bit 7 extended unless req_unsigned. Load half: selected half, bit 15 extended unless req_unsigned. Load word: full word, req_unsigned ignored.
- Stores return rsp_rdata=0, rsp_err=0.
- Array contents are not reset; only control state and outputs are.

## Timing

- Reset values: req_ready=1 (IDLE) after reset, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Accept at edge t -> rsp_valid high from cycle t+1+WAIT_STATES.
- Minimum request spacing 2+WAIT_STATES cycles (response handshake and next accept never share a cycle).
- rsp_ready high before rsp_valid has no effect; response still presented at least one cycle.
- Back-to-back store then load to same address: load returns the stored value (store committed before load executes).
- rst asserted in WAIT: return to IDLE immediately, pending store not committed. rst in RESP: rsp_valid drops asynchronously; already-committed store remains.
- req inputs ignored outside IDLE; initiator holds them until accepted.

## Test plan

- Reset, WAIT_STATES=1: req_ready=1, rsp_valid=0; store word 0xDEADBEEF at 0x10 accepted at t -> rsp_valid at t+2, rsp_err=0, rsp_rdata=0.
- Load byte 0x13 signed after above -> rsp_rdata=0xFFFFFFDE; unsigned -> 0x000000DE; load half 0x10 signed -> 0xFFFFBEEF.
- Store byte 0x55 at 0x11, then load word 0x10 -> 0xDEAD55EF; store half 0x1234 at 0x12 -> load word 0x12345 5EF i.e. 0x123455EF.
- Load word at 0x12, load half at 0x11, size=11, addr 0x1000 (DEPTH_WORDS=1024) -> each rsp_err=1, rsp_rdata=0; subsequent load word 0x10 unchanged 0x123455EF.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata stable, req_ready=0 throughout; new req_valid not accepted until cycle after rsp handshake.
- Store 0xAAAAAAAA at 0x20 with WAIT_STATES=3, assert rst during WAIT -> outputs return to reset values; later load 0x20 does not return 0xAAAAAAAA (prior value preserved).
